// File: rtl/ordered_sets_encoder_mlane_if.sv
// Ordered-set request / multi-lane encoded block bundle.
interface ordered_sets_encoder_mlane_if #(
  parameter int LANES  = 4,
  parameter int OS_NUM = 14
);
  logic [OS_NUM-1:0]     ordered_sets;
  logic                  os_valid;
  logic                  os_ready;
  logic                  cc_en;
  logic [LANES*66-1:0]   encoded_blocks;
  logic                  out_valid;
  logic                  cc_active;

  modport master (
    output ordered_sets, os_valid, cc_en,
    input  os_ready, encoded_blocks, out_valid, cc_active
  );

  modport slave (
    input  ordered_sets, os_valid, cc_en,
    output os_ready, encoded_blocks, out_valid, cc_active
  );
endinterface

// File: rtl/ordered_sets_encoder_mlane.sv
// Multi-lane 64b/66b ordered-set encoder with periodic
// clock-compensation bursts.
module ordered_sets_encoder_mlane #(
  parameter int LANES     = 4,
  parameter int OS_NUM    = 14,
  parameter int CC_PERIOD = 5000,
  parameter int CC_LEN    = 3
) (
  input logic clk,
  input logic rst,
  ordered_sets_encoder_mlane_if.slave bus
);

  typedef enum logic {RUN, CC_BURST} state_e;

  localparam int CW = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
  localparam int BW = (CC_LEN > 1) ? $clog2(CC_LEN) : 1;
  localparam logic [CW-1:0] CC_LAST = CW'(CC_PERIOD - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(CC_LEN - 1);
  localparam logic [7:0] BTF_IDLE = 8'h78;
  localparam logic [7:0] BTF_CC   = 8'h7c;

  function automatic logic [7:0] os_btf(input int idx);
    case (idx)
      0:       os_btf = 8'h1e;
      1:       os_btf = 8'h2d;
      2:       os_btf = 8'h33;
      3:       os_btf = 8'h4b;
      4:       os_btf = 8'h55;
      5:       os_btf = 8'h66;
      6:       os_btf = 8'h87;
      7:       os_btf = 8'h99;
      8:       os_btf = 8'haa;
      9:       os_btf = 8'hb4;
      10:      os_btf = 8'hcc;
      11:      os_btf = 8'hd2;
      12:      os_btf = 8'he1;
      13:      os_btf = 8'hff;
      default: os_btf = BTF_IDLE;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [CW-1:0]       cc_cnt_q, cc_cnt_d;
  logic [BW-1:0]       burst_q, burst_d;
  logic [LANES*66-1:0] enc_q, enc_d;
  logic                out_valid_q;
  logic                cc_active_q, cc_active_d;
  logic                cc_due;
  logic [7:0]          req_btf;
  logic [7:0]          btf;

  assign cc_due = bus.cc_en && (cc_cnt_q == CC_LAST);
  assign bus.os_ready = !rst && (state_q == RUN) && !cc_due;

  // Walk downward so the lowest set bit wins.
  always_comb begin
    req_btf = BTF_IDLE;
    for (int i = OS_NUM - 1; i >= 0; i--) begin
      if (bus.ordered_sets[i]) req_btf = os_btf(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    cc_cnt_d    = cc_cnt_q;
    burst_d     = burst_q;
    btf         = BTF_IDLE;
    cc_active_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (cc_due) begin
          cc_cnt_d = '0;
          burst_d  = '0;
          state_d  = CC_BURST;
        end else begin
          cc_cnt_d = bus.cc_en ? cc_cnt_q + CW'(1) : '0;
          if (bus.os_valid && bus.os_ready) btf = req_btf;
        end
      end
      CC_BURST: begin
        btf         = BTF_CC;
        cc_active_d = 1'b1;
        cc_cnt_d    = '0;
        if (burst_q == BURST_LAST) begin
          burst_d = '0;
          state_d = RUN;
        end else begin
          burst_d = burst_q + BW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    enc_d = '0;
    for (int k = 0; k < LANES; k++) begin
      enc_d[k*66 +: 66] = {2'b10, btf, 48'h0, 8'(k)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cc_cnt_q    <= '0;
      burst_q     <= '0;
      enc_q       <= '0;
      out_valid_q <= 1'b0;
      cc_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cc_cnt_q    <= cc_cnt_d;
      burst_q     <= burst_d;
      enc_q       <= enc_d;
      out_valid_q <= 1'b1;
      cc_active_q <= cc_active_d;
    end
  end

  assign bus.encoded_blocks = enc_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.cc_active      = cc_active_q;

endmodule

// File: tb/tb_ordered_sets_encoder_mlane.sv
// Directed bench for the multi-lane ordered-set encoder
// with a 16-cycle, 3-block CC cadence.
module tb_ordered_sets_encoder_mlane;
  localparam int LANES     = 4;
  localparam int OS_NUM    = 14;
  localparam int CC_PERIOD = 16;
  localparam int CC_LEN    = 3;
  localparam logic [7:0] IDLE = 8'h78;
  localparam logic [7:0] CCB  = 8'h7c;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;

  ordered_sets_encoder_mlane_if #(
    .LANES(LANES), .OS_NUM(OS_NUM)
  ) bus ();

  ordered_sets_encoder_mlane #(
    .LANES(LANES), .OS_NUM(OS_NUM),
    .CC_PERIOD(CC_PERIOD), .CC_LEN(CC_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] tb_btf(input int i);
    case (i)
      0:       tb_btf = 8'h1e;
      1:       tb_btf = 8'h2d;
      2:       tb_btf = 8'h33;
      3:       tb_btf = 8'h4b;
      4:       tb_btf = 8'h55;
      5:       tb_btf = 8'h66;
      6:       tb_btf = 8'h87;
      7:       tb_btf = 8'h99;
      8:       tb_btf = 8'haa;
      9:       tb_btf = 8'hb4;
      10:      tb_btf = 8'hcc;
      11:      tb_btf = 8'hd2;
      12:      tb_btf = 8'he1;
      default: tb_btf = 8'hff;
    endcase
  endfunction

  function automatic logic [LANES*66-1:0] exp_bus(input logic [7:0] b);
    logic [LANES*66-1:0] v;
    v = '0;
    for (int k = 0; k < LANES; k++) v[k*66 +: 66] = {2'b10, b, 48'h0, 8'(k)};
    return v;
  endfunction

  task automatic do_reset(input logic cc);
    rst = 1'b1;
    bus.cc_en = cc;
    bus.os_valid = 1'b0;
    bus.ordered_sets = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.cc_en = 1'b0;
    bus.os_valid = 1'b0;
    bus.ordered_sets = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.encoded_blocks !== '0) begin
      errors++;
      $display("FAIL reset_enc got=%h want=0", bus.encoded_blocks);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.cc_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b%b want=00", bus.out_valid, bus.cc_active);
    end
    checks++;
    if (bus.os_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got=%b want=0", bus.os_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.os_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready got=%b want=1", bus.os_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.encoded_blocks !== exp_bus(IDLE)) begin
      errors++;
      $display("FAIL release_idle v=%b got=%h want=%h",
               bus.out_valid, bus.encoded_blocks, exp_bus(IDLE));
    end
  endtask

  task automatic test_walking_one;
    bus.cc_en = 1'b0;
    bus.os_valid = 1'b1;
    for (int i = 0; i < OS_NUM; i++) begin
      bus.ordered_sets = 14'(1) << i;
      for (int c = 0; c < 5; c++) begin
        #1;
        checks++;
        if (bus.os_ready !== 1'b1) begin
          errors++;
          $display("FAIL walk_ready[%0d] got=%b want=1", i, bus.os_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.encoded_blocks !== exp_bus(tb_btf(i)) || bus.cc_active !== 1'b0) begin
          errors++;
          $display("FAIL walk[%0d] got=%h want=%h", i,
                   bus.encoded_blocks, exp_bus(tb_btf(i)));
        end
      end
    end
  endtask

  task automatic test_priority;
    bus.os_valid = 1'b1;
    bus.ordered_sets = 14'b00_0000_0010_1100;
    #1;
    @(negedge clk);
    checks++;
    if (bus.encoded_blocks !== exp_bus(tb_btf(2))) begin
      errors++;
      $display("FAIL prio_low got=%h want=%h", bus.encoded_blocks, exp_bus(tb_btf(2)));
    end
    bus.ordered_sets = 14'b11_0000_0000_0000;
    #1;
    @(negedge clk);
    checks++;
    if (bus.encoded_blocks !== exp_bus(tb_btf(12))) begin
      errors++;
      $display("FAIL prio_high got=%h want=%h", bus.encoded_blocks, exp_bus(tb_btf(12)));
    end
    bus.ordered_sets = '0;
    #1;
    checks++;
    if (bus.os_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready got=%b want=1", bus.os_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.encoded_blocks !== exp_bus(IDLE)) begin
      errors++;
      $display("FAIL zero_idle got=%h want=%h", bus.encoded_blocks, exp_bus(IDLE));
    end
    bus.os_valid = 1'b0;
  endtask

  task automatic test_cc_cadence;
    logic [7:0] eb;
    do_reset(1'b1);
    bus.os_valid = 1'b1;
    bus.ordered_sets = 14'd1;
    for (int p = 0; p < 2; p++) begin
      for (int j = 1; j <= 19; j++) begin
        #1;
        checks++;
        if (bus.os_ready !== (j < 16)) begin
          errors++;
          $display("FAIL cad_ready p%0d c%0d got=%b want=%b", p, j, bus.os_ready, j < 16);
        end
        @(negedge clk);
        eb = (j < 16) ? tb_btf(0) : (j == 16) ? IDLE : CCB;
        checks++;
        if (bus.encoded_blocks !== exp_bus(eb) || bus.cc_active !== (j > 16)) begin
          errors++;
          $display("FAIL cad_out p%0d c%0d cca=%b got=%h want=%h",
                   p, j, bus.cc_active, bus.encoded_blocks, exp_bus(eb));
        end
      end
    end
    bus.os_valid = 1'b0;
  endtask

  task automatic test_collision;
    do_reset(1'b1);
    repeat (15) @(negedge clk);
    bus.os_valid = 1'b1;
    bus.ordered_sets = 14'(1) << 5;
    #1;
    checks++;
    if (bus.os_ready !== 1'b0) begin
      errors++;
      $display("FAIL coll_ready got=%b want=0", bus.os_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.encoded_blocks !== exp_bus(IDLE) || bus.cc_active !== 1'b0) begin
      errors++;
      $display("FAIL coll_idle got=%h want=%h", bus.encoded_blocks, exp_bus(IDLE));
    end
    for (int j = 0; j < CC_LEN; j++) begin
      #1;
      checks++;
      if (bus.os_ready !== 1'b0) begin
        errors++;
        $display("FAIL coll_burst_ready[%0d] got=%b want=0", j, bus.os_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.encoded_blocks !== exp_bus(CCB) || bus.cc_active !== 1'b1) begin
        errors++;
        $display("FAIL coll_cc[%0d] cca=%b got=%h", j, bus.cc_active, bus.encoded_blocks);
      end
    end
    #1;
    checks++;
    if (bus.os_ready !== 1'b1) begin
      errors++;
      $display("FAIL coll_resume_ready got=%b want=1", bus.os_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.encoded_blocks !== exp_bus(tb_btf(5)) || bus.cc_active !== 1'b0) begin
      errors++;
      $display("FAIL coll_accept got=%h want=%h", bus.encoded_blocks, exp_bus(tb_btf(5)));
    end
    bus.os_valid = 1'b0;
  endtask

  task automatic test_cc_en_fall;
    do_reset(1'b1);
    repeat (17) @(negedge clk);
    checks++;
    if (bus.encoded_blocks !== exp_bus(CCB) || bus.cc_active !== 1'b1) begin
      errors++;
      $display("FAIL fall_first cca=%b got=%h", bus.cc_active, bus.encoded_blocks);
    end
    bus.cc_en = 1'b0;
    for (int j = 0; j < CC_LEN - 1; j++) begin
      #1;
      @(negedge clk);
      checks++;
      if (bus.encoded_blocks !== exp_bus(CCB) || bus.cc_active !== 1'b1) begin
        errors++;
        $display("FAIL fall_rest[%0d] cca=%b got=%h", j, bus.cc_active, bus.encoded_blocks);
      end
    end
    for (int j = 0; j < 40; j++) begin
      #1;
      checks++;
      if (bus.os_ready !== 1'b1) begin
        errors++;
        $display("FAIL fall_ready[%0d] got=%b want=1", j, bus.os_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.encoded_blocks !== exp_bus(IDLE) || bus.cc_active !== 1'b0) begin
        errors++;
        $display("FAIL fall_idle[%0d] cca=%b got=%h", j, bus.cc_active, bus.encoded_blocks);
      end
    end
  endtask

  task automatic test_reset_midburst;
    logic [7:0] eb;
    do_reset(1'b1);
    repeat (18) @(negedge clk);
    checks++;
    if (bus.encoded_blocks !== exp_bus(CCB) || bus.cc_active !== 1'b1) begin
      errors++;
      $display("FAIL mid_second cca=%b got=%h", bus.cc_active, bus.encoded_blocks);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.encoded_blocks !== '0 || bus.out_valid !== 1'b0 || bus.cc_active !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst v=%b cca=%b got=%h want=0",
               bus.out_valid, bus.cc_active, bus.encoded_blocks);
    end
    checks++;
    if (bus.os_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_ready got=%b want=0", bus.os_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= 19; j++) begin
      #1;
      checks++;
      if (bus.os_ready !== (j < 16)) begin
        errors++;
        $display("FAIL mid_ready c%0d got=%b want=%b", j, bus.os_ready, j < 16);
      end
      @(negedge clk);
      eb = (j <= 16) ? IDLE : CCB;
      checks++;
      if (bus.encoded_blocks !== exp_bus(eb) || bus.cc_active !== (j > 16)
          || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL mid_out c%0d cca=%b got=%h want=%h",
                 j, bus.cc_active, bus.encoded_blocks, exp_bus(eb));
      end
    end
  endtask

  initial begin
    test_reset();
    test_walking_one();
    test_priority();
    test_cc_cadence();
    test_collision();
    test_cc_en_fall();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ordered_sets_encoder_mlane.md
ORDERED_SETS_ENCODER_MLANE -- requirements
Module: ordered_sets_encoder_mlane

Interface
REQ-001 SHALL have parameter LANES, default 4, number of output lanes (1..16).
REQ-002 SHALL have parameter OS_NUM, default 14, width of the ordered-set request vector.
REQ-003 SHALL have parameter CC_PERIOD, default 5000, RUN-state cycles between clock-compensation bursts (>=2).
REQ-004 SHALL have parameter CC_LEN, default 3, CC blocks per burst (>=1).
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port ordered_sets  input  OS_NUM  request vector, bit i requests ordered set i.
REQ-008 SHALL have port os_valid  input  1  request vector valid.
REQ-009 SHALL have port os_ready  output  1  request accepted this cycle when os_valid and os_ready are both high.
REQ-010 SHALL have port cc_en  input  1  enables clock-compensation insertion.
REQ-011 SHALL have port encoded_blocks  output  LANES*66  lane k occupies bits [66k+65:66k].
REQ-012 SHALL have port out_valid  output  1  encoded_blocks valid.
REQ-013 SHALL have port cc_active  output  1  high while encoded_blocks carries CC blocks.

Function
REQ-014 SHALL implement a two-state FSM: RUN, CC_BURST.
REQ-015 SHALL format each lane block as {2'b10, BTF[7:0], 48'h0, lane index[7:0]}; BTF is the aurora_pkg block-type constant of the selected set.
REQ-016 SHALL, in RUN with os_valid and os_ready, select the lowest-index set bit of ordered_sets and emit that set on all lanes.
REQ-017 SHALL emit the Idle block on all lanes in RUN when no request is accepted, including os_valid high with ordered_sets == 0 (accepted, produces Idle).
REQ-018 SHALL emit the CC block on all lanes every cycle in CC_BURST.
REQ-019 SHALL register encoded_blocks, out_valid, cc_active: the block decided in cycle n appears after the edge ending cycle n (latency 1).
REQ-020 SHALL drive os_ready combinationally = (state == RUN) && !cc_due, with cc_due = cc_en && (cc_cnt == CC_PERIOD-1).
REQ-021 SHALL increment cc_cnt (width $clog2(CC_PERIOD)) each RUN cycle while cc_en is high, and hold it at 0 while cc_en is low.
REQ-022 SHALL, in a RUN cycle with cc_due, emit Idle, clear cc_cnt, clear burst_cnt and enter CC_BURST next cycle; a simultaneous os_valid is not accepted.
REQ-023 SHALL increment burst_cnt each CC_BURST cycle and return to RUN after the cycle with burst_cnt == CC_LEN-1 (exactly CC_LEN CC cycles).
REQ-024 SHALL hold cc_cnt at 0 during CC_BURST.
REQ-025 SHALL complete an active burst if cc_en falls mid-burst; cc_en low only prevents new bursts.
REQ-026 SHALL drive out_valid high from the first edge after reset release onward.
REQ-027 SHALL drive cc_active high exactly on output cycles carrying CC blocks.

Reset
REQ-028 SHALL, on rst high (asynchronously, including mid-burst), force state RUN, cc_cnt 0, burst_cnt 0, encoded_blocks all zero, out_valid 0, cc_active 0.
REQ-029 SHALL drive os_ready 0 while rst is high.
REQ-030 SHALL resume normal operation on the first edge after rst falls, cc_cnt counting from 0.

Verification
REQ-031 SHALL cover walking one: LANES=4, cc_en=0, os_valid=1, ordered_sets=1<<i for i=0..13 held 5 cycles each -> each output cycle shows BTF of set i on all 4 lanes, lane byte 0..3, one cycle after the input.
REQ-032 SHALL cover priority: ordered_sets=14'b00_0000_0010_1100 -> set 2 emitted; ordered_sets=0, os_valid=1 -> Idle, os_ready=1.
REQ-033 SHALL cover CC cadence: CC_PERIOD=16, CC_LEN=3, cc_en=1 from reset, os_valid=1 -> os_ready low on RUN cycle 16, three CC blocks with cc_active=1 and os_ready=0, repeating every 19 cycles.
REQ-034 SHALL cover collision: request presented in the cc_due cycle -> not accepted, Idle then CC burst, request accepted on first RUN cycle after burst.
REQ-035 SHALL cover cc_en falling after first CC block -> remaining 2 CC blocks still emitted, no further bursts.
REQ-036 SHALL cover rst pulse during second CC block -> outputs zero immediately, out_valid 0, after release RUN with next burst after 16 RUN cycles.
